// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave exposing NUM_REGS byte-strobed registers; write AW/W are captured
// independently, reads are single-beat with the register value sampled at the AR handshake.
module axi_lite_reg_bank #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 16,
  parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr
);
  localparam int             STRB_W = DATA_W / 8;
  localparam int             OFF    = $clog2(STRB_W);
  localparam int             IDX_W  = ADDR_W - OFF;
  localparam logic [IDX_W:0] NREG   = (IDX_W+1)'(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic                            aw_held, w_held;
  logic [IDX_W-1:0]                aw_idx;
  logic [DATA_W-1:0]               w_data;
  logic [STRB_W-1:0]               w_strb;
  logic                            aw_fire, w_fire, ar_fire, wr_go, wr_ok, rd_ok;
  logic [IDX_W-1:0]                wr_idx, rd_idx;
  logic [DATA_W-1:0]               wr_data, rd_val;
  logic [STRB_W-1:0]               wr_strb;
  logic                            unused_lsb;

  // Byte-offset address bits never select anything.
  assign unused_lsb = ^{awaddr[OFF-1:0], araddr[OFF-1:0]};

  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held && !bvalid;
  assign arready = !rvalid;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign ar_fire = arvalid && arready;

  // Bypass the holding registers so a same-cycle AW+W commits on this edge.
  assign wr_idx  = aw_held ? aw_idx : awaddr[ADDR_W-1:OFF];
  assign wr_data = w_held ? w_data : wdata;
  assign wr_strb = w_held ? w_strb : wstrb;
  assign wr_go   = (aw_held || aw_fire) && (w_held || w_fire) && !bvalid;
  assign wr_ok   = {1'b0, wr_idx} < NREG;
  assign rd_idx  = araddr[ADDR_W-1:OFF];
  assign rd_ok   = {1'b0, rd_idx} < NREG;
  assign reg_q   = regs;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_idx == IDX_W'(i)) rd_val = regs[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs    <= {NUM_REGS{RST_VAL}};
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      reg_wr  <= '0;
    end else begin
      reg_wr <= '0;
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_idx  <= awaddr[ADDR_W-1:OFF];
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb;
      end
      if (wr_go) begin
        bvalid <= 1'b1;
        bresp  <= wr_ok ? 2'b00 : 2'b10;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_ok && wr_idx == IDX_W'(i)) begin
            reg_wr[i] <= 1'b1;
            for (int b = 0; b < STRB_W; b++)
              if (wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end else if (bvalid && bready) begin
        bvalid  <= 1'b0;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rresp  <= 2'b00;
      rdata  <= '0;
    end else if (ar_fire) begin
      rvalid <= 1'b1;
      rresp  <= rd_ok ? 2'b00 : 2'b10;
      rdata  <= rd_ok ? rd_val : '0;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Scoreboard bench for axi_lite_reg_bank: expected B/R responses are queued as stimulus
// is driven and popped by a negedge monitor on each handshake.
module tb_axi_lite_reg_bank;
  localparam int            AW = 12;
  localparam int            DW = 32;
  localparam int            NR = 16;
  localparam logic [DW-1:0] RV = 32'hC0DE_0001;

  logic              clk, rst;
  logic [AW-1:0]     awaddr, araddr;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [DW-1:0]     wdata, rdata;
  logic [DW/8-1:0]   wstrb;
  logic [1:0]        bresp, rresp;
  logic [NR*DW-1:0]  reg_q;
  logic [NR-1:0]     reg_wr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [NR-1:0][DW-1:0] mdl;
  logic [1:0]            bq[$];
  logic [33:0]           rq[$];

  axi_lite_reg_bank #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .RST_VAL(RV)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_q(reg_q), .reg_wr(reg_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [NR*DW-1:0] got, input logic [NR*DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One handshake is pending per negedge sample, since inputs only move just after posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid && bready) begin
        chk("bq_nonempty", bq.size() != 0, 1);
        if (bq.size() != 0) chk("bresp", bresp, bq.pop_front());
      end
      if (rvalid && rready) begin
        chk("rq_nonempty", rq.size() != 0, 1);
        if (rq.size() != 0) chk("rresp_rdata", {rresp, rdata}, rq.pop_front());
      end
    end
  end

  // W leads AW by 'lead' cycles (0 = same cycle).
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s, input int lead);
    logic [9:0]    idx;
    logic [NR-1:0] onehot;
    idx    = a[AW-1:2];
    onehot = '0;
    if (idx < NR) begin
      onehot[idx[3:0]] = 1'b1;
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx[3:0]][b*8 +: 8] = d[b*8 +: 8];
      bq.push_back(2'b00);
    end else begin
      bq.push_back(2'b10);
    end
    chk("awready_idle", awready, 1);
    chk("wready_idle", wready, 1);
    wdata = d; wstrb = s; wvalid = 1'b1;
    if (lead > 0) begin
      step();
      wvalid = 1'b0;
      chk("wready_held", wready, 0);
      repeat (lead - 1) step();
      chk("no_b_before_aw", bvalid, 0);
    end
    awaddr = a; awvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid", bvalid, 1);
    chk("reg_q", reg_q, mdl);
    chk("reg_wr", reg_wr, onehot);
    step();
    chk("reg_wr_pulse", reg_wr, 0);
    chk("b_done", bvalid, 0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    logic [9:0] idx;
    idx = a[AW-1:2];
    if (idx < NR) rq.push_back({2'b00, mdl[idx[3:0]]});
    else          rq.push_back({2'b10, 32'h0});
    chk("arready_idle", arready, 1);
    araddr = a; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("rvalid", rvalid, 1);
    step();
    chk("r_done", rvalid, 0);
  endtask

  initial begin
    rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
    mdl = {NR{RV}};
    step(); step();
    rst = 1'b0;
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_reg_wr", reg_wr, 0);
    chk("rst_reg_q", reg_q, mdl);

    wr(12'h004, 32'hDEADBEEF, 4'hF, 0);
    chk("r1_value", reg_q[1*DW +: DW], 32'hDEADBEEF);
    wr(12'h008, 32'hFFFFFFFF, 4'hF, 0);
    wr(12'h008, 32'h1234ABCD, 4'h3, 3);
    chk("r2_partial", reg_q[2*DW +: DW], 32'hFFFFABCD);
    wr(12'h00F, 32'h11223344, 4'b1010, 1);
    wr(12'h00C, 32'h99999999, 4'h0, 0);
    rd(12'h004);
    rd(12'h00A);
    rd(12'h00C);
    rd(12'h3FC);

    wr(12'h040, 32'h5A5A5A5A, 4'hF, 0);
    rd(12'h040);

    // B backpressure: no new AW/W may be taken while the response waits.
    mdl[3] = 32'h0BADF00D;
    bq.push_back(2'b00);
    bready = 1'b0;
    awaddr = 12'h00C; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp_bvalid", bvalid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_bvalid", bvalid, 1);
      chk("bp_hold_bresp", bresp, 0);
      chk("bp_awready", awready, 0);
      chk("bp_wready", wready, 0);
      chk("bp_reg_q", reg_q, mdl);
      awaddr = 12'h010; wdata = 32'h66666666; awvalid = 1'b1; wvalid = 1'b1;
      step();
    end
    chk("bp_end_bvalid", bvalid, 1);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    step();
    chk("bp_released", bvalid, 0);
    chk("bp_aw_not_taken", awready, 1);
    chk("bp_w_not_taken", wready, 1);
    chk("bp_reg_q_after", reg_q, mdl);

    // Read in the same cycle as a write to the same register sees the old value.
    wr(12'h004, 32'h000000AA, 4'hF, 0);
    rq.push_back({2'b00, mdl[1]});
    mdl[1] = 32'h00000055;
    bq.push_back(2'b00);
    awaddr = 12'h004; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 12'h004; arvalid = 1'b1;
    chk("sim_arready", arready, 1);
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("sim_bvalid", bvalid, 1);
    chk("sim_rvalid", rvalid, 1);
    chk("sim_reg_q", reg_q, mdl);
    chk("sim_reg_wr", reg_wr, 16'h0002);
    step();
    rd(12'h004);

    // R backpressure holds the response and blocks AR.
    rq.push_back({2'b00, mdl[2]});
    rready = 1'b0;
    araddr = 12'h008; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rbp_rvalid", rvalid, 1);
      chk("rbp_arready", arready, 0);
      chk("rbp_rdata", rdata, 32'hFFFFABCD);
      step();
    end
    rready = 1'b1;
    step();
    chk("rbp_released", rvalid, 0);

    // Reset with AW held and W still outstanding.
    awaddr = 12'h010; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("mid_aw_held", awready, 0);
    chk("mid_w_open", wready, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mdl = {NR{RV}};
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_reg_q", reg_q, mdl);
    chk("mid_rst_awready", awready, 1);
    chk("mid_rst_wready", wready, 1);
    chk("mid_rst_arready", arready, 1);
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("mid_no_stale_aw", bvalid, 0);
    mdl[5] = 32'h77;
    bq.push_back(2'b00);
    awaddr = 12'h014; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    chk("mid_complete_bvalid", bvalid, 1);
    chk("mid_complete_reg_q", reg_q, mdl);
    step();

    step();
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_reg_bank.md
AXI_LITE_REG_BANK -- requirements
Module: axi_lite_reg_bank

Interface
REQ-001 SHALL have parameter ADDR_W, 12, byte-address width.
REQ-002 SHALL have parameter DATA_W, 32, data width; legal values 32 or 64.
REQ-003 SHALL have parameter NUM_REGS, 16, register count; 1..2**(ADDR_W-log2(DATA_W/8)).
REQ-004 SHALL have parameter RST_VAL, 0, reset value of every register, DATA_W bits.
REQ-005 SHALL have one clock and a synchronous, active-high reset, declared first:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
REQ-006 SHALL have the write ports:
- awaddr  in  ADDR_W  write address.
- awvalid  in  1  write-address valid.
- awready  out  1  write-address ready.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte strobes.
- wvalid  in  1  write-data valid.
- wready  out  1  write-data ready.
- bresp  out  2  write response.
- bvalid  out  1  response valid.
- bready  in  1  response ready.
REQ-007 SHALL have the read ports:
- araddr  in  ADDR_W  read address.
- arvalid  in  1  read-address valid.
- arready  out  1  read-address ready.
- rdata  out  DATA_W  read data.
- rresp  out  2  read response.
- rvalid  out  1  read valid.
- rready  in  1  read ready.
REQ-008 SHALL have the register ports:
- reg_q  out  NUM_REGS*DATA_W  register contents; register i at bits [i*DATA_W +: DATA_W].
- reg_wr  out  NUM_REGS  one-cycle pulse per register written.

Function
REQ-009 SHALL compute the register index as addr[ADDR_W-1:log2(DATA_W/8)] and ignore the low byte-offset bits.
REQ-010 SHALL capture AW and W independently into holding registers; the two may arrive in either order or in the same cycle.
REQ-011 SHALL drive awready=1 only while no AW is held and bvalid=0; wready SHALL follow the same rule for W.
REQ-012 SHALL perform the write in the cycle after both AW and W are held, and assert bvalid in that same cycle.
REQ-013 SHALL give write latency: if AW and W handshake in cycle N, then bvalid=1 and the register update are visible in cycle N+1.
REQ-014 SHALL, on a write, update only the bytes whose wstrb bit is 1; wstrb=0 leaves the register unchanged, still pulses reg_wr, and gives bresp=OKAY.
REQ-015 SHALL hold bvalid and bresp stable until bready=1, then clear both holding registers; new AW/W SHALL be accepted from the next cycle.
REQ-016 SHALL, for an index >= NUM_REGS, give bresp=SLVERR (2'b10), change no register and pulse no reg_wr.
REQ-017 SHALL drive arready = !rvalid; an AR handshake in cycle N gives rvalid=1 in cycle N+1.
REQ-018 SHALL sample rdata from the register value at the AR handshake cycle; a same-cycle write to that register SHALL return the old value.
REQ-019 SHALL, for an out-of-range read, give rresp=SLVERR and rdata=0; otherwise rresp=OKAY (2'b00).
REQ-020 SHALL hold rdata, rresp and rvalid stable until rready=1.
REQ-021 SHALL keep the read and write paths fully independent; simultaneous read and write SHALL stall neither path.

Reset
REQ-022 SHALL, while rst=1 on a clock edge, set every register to RST_VAL, clear both holding registers, and drive bvalid=rvalid=0, bresp=rresp=0, rdata=0 and reg_wr=0.
REQ-023 SHALL make awready, wready and arready equal 1 in the first cycle after rst falls.
REQ-024 SHALL make reset mid-transaction discard all held or pending AW, W, B and R state, with no partial register update.

Verification
REQ-025 Bench SHALL cover: AW and W in the same cycle, addr 0x004, wdata 0xDEADBEEF, wstrb 0xF -> next cycle bvalid=1, bresp=0, reg 1 = 0xDEADBEEF, reg_wr=0x0002 for 1 cycle.
REQ-026 Bench SHALL cover: W three cycles before AW, addr 0x008, wstrb 0x3, wdata 0x1234ABCD, reg 2 previously 0xFFFFFFFF -> reg 2 = 0xFFFFABCD.
REQ-027 Bench SHALL cover: write to addr 0x040 with NUM_REGS=16 -> bresp=2'b10, no reg_q change, reg_wr=0; read from 0x040 -> rresp=2'b10, rdata=0.
REQ-028 Bench SHALL cover: bready held 0 for 5 cycles -> bvalid stays 1, awready=wready=0 throughout, and a new AW offered in that window is not accepted.
REQ-029 Bench SHALL cover: AR to addr 0x004 in the same cycle as a write of 0x55 to reg 1 (old value 0xAA) -> rdata=0xAA; a subsequent read returns 0x55.
REQ-030 Bench SHALL cover: rst asserted while AW is held and W is outstanding -> after reset no bvalid, registers equal RST_VAL, all ready outputs 1.
